// File: rtl/i2c_reg_slave.sv
// I2C register target: 7-bit address, 8-bit register pointer, auto-increment writes and reads.
// Latency: pins pass through a 2-flop sync plus history flop (~3 clk); wr_valid pulses 1 clk after the 8th SCL rise.
// Backpressure: none; the master paces every bit via SCL, and bytes aimed at out-of-range registers are NACKed.
module i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h10,
  parameter int         REG_NUM    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam int         IW      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [8:0] REG_LIM = 9'(REG_NUM);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t     state;
  logic [7:0] regs [REG_NUM];
  logic [7:0] shreg;
  logic [7:0] ptr;
  logic [3:0] bit_cnt;
  logic       rw;
  logic       ack_ph;
  logic       sda_oe;

  logic scl_m, scl_s, scl_d;
  logic sda_m, sda_s, sda_d;

  // Open-drain pad: only ever pull low or let the bus float.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Resynchronise both bus lines and keep one history sample for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      scl_d <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_m <= scl;
      scl_s <= scl_m;
      scl_d <= scl_s;
      sda_m <= sda;
      sda_s <= sda_m;
      sda_d <= sda_s;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = ~sda_s & sda_d & scl_s;
  assign stop_det  = sda_s & ~sda_d & scl_s;

  logic [7:0] shift_in;
  logic       ptr_ok;
  logic       ptr_last;
  logic [7:0] ptr_next;
  logic [7:0] rd_byte;
  logic       dbg_ok;

  assign shift_in = {shreg[6:0], sda_s};
  assign ptr_ok   = ({1'b0, ptr} < REG_LIM);
  assign ptr_last = ({1'b0, ptr} == (REG_LIM - 9'd1));
  assign ptr_next = ptr_last ? 8'h00 : (ptr + 8'd1);
  // Reads from unimplemented registers float the bus, which the master sees as 0xFF.
  assign rd_byte  = ptr_ok ? regs[ptr[IW-1:0]] : 8'hFF;
  assign dbg_ok   = ({1'b0, dbg_addr} < REG_LIM);
  assign dbg_data = dbg_ok ? regs[dbg_addr[IW-1:0]] : 8'h00;

  // Protocol FSM: bus conditions first, then per-state bit handling on SCL edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= 8'h00;
      ptr      <= 8'h00;
      bit_cnt  <= 4'd0;
      rw       <= 1'b0;
      ack_ph   <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= 8'h00;
      wr_data  <= 8'h00;
      for (int i = 0; i < REG_NUM; i++) regs[i] <= 8'h00;
    end else begin
      wr_valid <= 1'b0;
      if (start_det) begin
        // Repeated START keeps the pointer so a pointer write can be followed by a read.
        state   <= DEV_ADDR;
        bit_cnt <= 4'd0;
        ack_ph  <= 1'b0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_det) begin
        state  <= IDLE;
        ack_ph <= 1'b0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sda_oe <= 1'b0;
          end
          DEV_ADDR: begin
            if (scl_rise) begin
              shreg <= shift_in;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                rw      <= shift_in[0];
                state   <= (shift_in[7:1] == SLAVE_ADDR) ? DEV_ACK : WAIT_STOP;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          REG_ADDR: begin
            if (scl_rise) begin
              shreg <= shift_in;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                ptr     <= shift_in;
                state   <= REG_ACK;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shreg <= shift_in;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                if (ptr_ok) begin
                  regs[ptr[IW-1:0]] <= shift_in;
                  wr_valid <= 1'b1;
                  wr_addr  <= ptr;
                  wr_data  <= shift_in;
                  state    <= WR_ACK;
                end else begin
                  state <= WAIT_STOP;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          DEV_ACK, REG_ACK, WR_ACK: begin
            // First SCL fall starts the ACK low pulse, the second one ends it.
            if (scl_fall) begin
              if (!ack_ph) begin
                ack_ph <= 1'b1;
                sda_oe <= 1'b1;
              end else begin
                ack_ph  <= 1'b0;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                if (state == DEV_ACK) begin
                  if (rw) begin
                    shreg  <= rd_byte;
                    sda_oe <= ~rd_byte[7];
                    state  <= RD_DATA;
                  end else begin
                    state <= REG_ADDR;
                  end
                end else if (state == REG_ACK) begin
                  state <= WR_DATA;
                end else begin
                  ptr   <= ptr_next;
                  state <= WR_DATA;
                end
              end
            end
          end
          RD_DATA: begin
            // bit_cnt counts bits already clocked out to the master.
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                ack_ph <= 1'b0;
                state  <= RD_ACK;
              end else begin
                sda_oe <= ~shreg[3'd7 - bit_cnt[2:0]];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                ack_ph <= 1'b1;
                ptr    <= ptr_next;
              end else begin
                state <= WAIT_STOP;
              end
            end else if (scl_fall && ack_ph) begin
              ack_ph  <= 1'b0;
              bit_cnt <= 4'd0;
              shreg   <= rd_byte;
              sda_oe  <= ~rd_byte[7];
              state   <= RD_DATA;
            end
          end
          WAIT_STOP: begin
            sda_oe <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed I2C master driving the register target, checked against a byte-level protocol model.
// Latency: each bus quarter-period is ~10 system clocks, so DUT reactions settle well within one quarter.
// Backpressure: none; the bench paces the bus and the compare process samples on every falling clk.
module tb_i2c_reg_slave;

  localparam int Q = 203;

  localparam int P_IDLE = 0;
  localparam int P_ADDR = 1;
  localparam int P_REG  = 2;
  localparam int P_DATA = 3;
  localparam int P_READ = 4;
  localparam int P_IGN  = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_low;
  wire        sda;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_data;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_reg_slave #(.SLAVE_ADDR(7'h10), .REG_NUM(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #10 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          n_wr  = 0;
  logic [7:0]  m_regs [64];
  logic [7:0]  m_ptr;
  int          m_ph;
  logic [7:0]  m_last_a;
  logic [7:0]  m_last_d;
  logic [15:0] exp_q [$];
  logic [15:0] e;
  bit          dbg_chk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- byte-level protocol model ----------------
  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
    m_ptr    = 8'h00;
    m_ph     = P_IDLE;
    m_last_a = 8'h00;
    m_last_d = 8'h00;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, output bit ack);
    ack = 1'b0;
    case (m_ph)
      P_ADDR: begin
        if (b[7:1] == 7'h10) begin
          ack  = 1'b1;
          m_ph = b[0] ? P_READ : P_REG;
        end else begin
          m_ph = P_IGN;
        end
      end
      P_REG: begin
        ack   = 1'b1;
        m_ptr = b;
        m_ph  = P_DATA;
      end
      P_DATA: begin
        if (m_ptr < 8'd64) begin
          ack = 1'b1;
          m_regs[m_ptr[5:0]] = b;
          exp_q.push_back({m_ptr, b});
          m_ptr = (m_ptr == 8'd63) ? 8'd0 : m_ptr + 8'd1;
        end else begin
          m_ph = P_IGN;
        end
      end
      default: ack = 1'b0;
    endcase
  endtask

  // ---------------- bus master ----------------
  task automatic i2c_start();
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b1; m_ph = P_ADDR; #Q;
    scl = 1'b0;   #Q;
    check("busy_after_start", busy, 1);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b0; #Q;
    m_ph = P_IDLE;
    check("busy_after_stop", busy, 0);
  endtask

  task automatic send_bit(input bit b);
    m_low = ~b; #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
  endtask

  task automatic recv_bit(output bit b);
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    b = (sda === 1'b0) ? 1'b0 : 1'b1;
    #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic wr_byte(input logic [7:0] b, input string nm);
    bit ack;
    bit s;
    model_byte(b, ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(s);
    check({nm, "_ack"}, s, ack ? 1'b0 : 1'b1);
  endtask

  task automatic rd_byte(input bit ack, input string nm, output logic [7:0] v);
    logic [7:0] expv;
    bit s;
    expv = (m_ptr < 8'd64) ? m_regs[m_ptr[5:0]] : 8'hFF;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(s);
      v[i] = s;
    end
    check({nm, "_model"}, v, expv);
    send_bit(~ack);
    if (ack) m_ptr = (m_ptr == 8'd63) ? 8'd0 : m_ptr + 8'd1;
    else     m_ph  = P_IGN;
  endtask

  task automatic dbg_rd(input logic [7:0] a, output logic [7:0] v);
    @(posedge clk); #1;
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  task automatic sweep();
    dbg_chk = 1'b1;
    for (int a = 0; a < 72; a++) begin
      @(posedge clk); #1;
      dbg_addr = a[7:0];
    end
    @(posedge clk); #1;
    dbg_addr = 8'hFF;
    @(posedge clk); #1;
    dbg_chk = 1'b0;
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (rst) begin
      check("wr_valid_in_reset", wr_valid, 0);
    end else begin
      if (wr_valid) begin
        n_wr++;
        check("wr_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e[15:8]);
          check("wr_data", wr_data, e[7:0]);
          m_last_a = e[15:8];
          m_last_d = e[7:0];
        end
      end else begin
        check("wr_hold", {wr_addr, wr_data}, {m_last_a, m_last_d});
      end
      if (!m_low && (m_ph == P_IDLE || m_ph == P_IGN))
        check("sda_quiet", sda === 1'b0, 0);
      if (dbg_chk)
        check("dbg_sweep", dbg_data, (dbg_addr < 8'd64) ? m_regs[dbg_addr[5:0]] : 8'h00);
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: time %0t exceeded bound", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [7:0] v;
    logic [7:0] t;
    rst = 1'b1; scl = 1'b1; m_low = 1'b0; dbg_addr = 8'h00; dbg_chk = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_sda", sda, 1);
    check("rst_dbg", dbg_data, 8'h00);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // single write
    i2c_start();
    wr_byte(8'h20, "t1_dev");
    wr_byte(8'h02, "t1_reg");
    wr_byte(8'h55, "t1_dat");
    i2c_stop();
    check("t1_nwr", n_wr, 1);
    dbg_rd(8'h02, v);
    check("t1_reg2", v, 8'h55);
    sweep();

    // burst with pointer wrap
    i2c_start();
    wr_byte(8'h20, "t2_dev");
    wr_byte(8'h3E, "t2_reg");
    wr_byte(8'hA1, "t2_d0");
    wr_byte(8'hB2, "t2_d1");
    wr_byte(8'hC3, "t2_d2");
    i2c_stop();
    check("t2_nwr", n_wr, 4);
    dbg_rd(8'h3E, v); check("t2_reg3e", v, 8'hA1);
    dbg_rd(8'h3F, v); check("t2_reg3f", v, 8'hB2);
    dbg_rd(8'h00, v); check("t2_reg00", v, 8'hC3);
    check("t2_hold", {wr_addr, wr_data}, 16'h00C3);

    // wrong device address, then a valid frame
    i2c_start();
    wr_byte(8'h22, "t3_dev");
    wr_byte(8'h01, "t3_b1");
    wr_byte(8'h99, "t3_b2");
    i2c_stop();
    check("t3_nwr", n_wr, 4);
    sweep();
    i2c_start();
    wr_byte(8'h20, "t3v_dev");
    wr_byte(8'h10, "t3v_reg");
    wr_byte(8'h66, "t3v_dat");
    i2c_stop();
    check("t3_nwr_after", n_wr, 5);
    dbg_rd(8'h10, v); check("t3_reg10", v, 8'h66);

    // pointer write, repeated START, two-byte read
    i2c_start();
    wr_byte(8'h20, "t4w_dev");
    wr_byte(8'h05, "t4w_reg");
    wr_byte(8'h5A, "t4w_d0");
    wr_byte(8'hC3, "t4w_d1");
    i2c_stop();
    i2c_start();
    wr_byte(8'h20, "t4_dev");
    wr_byte(8'h05, "t4_reg");
    i2c_start();
    wr_byte(8'h21, "t4_devr");
    rd_byte(1'b1, "t4_rd0", v);
    check("t4_rd0", v, 8'h5A);
    rd_byte(1'b0, "t4_rd1", v);
    check("t4_rd1", v, 8'hC3);
    #Q;
    check("t4_released", sda, 1);
    i2c_stop();
    check("t4_nwr", n_wr, 7);

    // out-of-range pointer: write NACKed, read returns 0xFF
    i2c_start();
    wr_byte(8'h20, "t5_dev");
    wr_byte(8'h50, "t5_reg");
    wr_byte(8'h11, "t5_dat");
    i2c_stop();
    check("t5_nwr", n_wr, 7);
    i2c_start();
    wr_byte(8'h20, "t5r_dev");
    wr_byte(8'h50, "t5r_reg");
    i2c_start();
    wr_byte(8'h21, "t5r_devr");
    rd_byte(1'b0, "t5_rd", v);
    check("t5_rd", v, 8'hFF);
    i2c_stop();

    // STOP after 4 data bits
    i2c_start();
    wr_byte(8'h20, "t6_dev");
    wr_byte(8'h07, "t6_reg");
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    check("t6_nwr", n_wr, 7);
    dbg_rd(8'h07, v); check("t6_reg7", v, 8'h00);
    check("t6_sda", sda, 1);

    // reset while the target holds an ACK low
    i2c_start();
    t = 8'h20;
    for (int i = 7; i >= 0; i--) send_bit(t[i]);
    m_low = 1'b0;
    #1;
    check("t7_ack_driven", sda, 0);
    rst = 1'b1;
    model_reset();
    #1;
    check("t7_sda_released", sda, 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    i2c_stop();
    dbg_rd(8'h05, v); check("t7_reg5_cleared", v, 8'h00);
    sweep();
    i2c_start();
    wr_byte(8'h20, "t7_dev");
    wr_byte(8'h01, "t7_reg");
    wr_byte(8'h3C, "t7_dat");
    i2c_stop();
    check("t7_nwr", n_wr, 8);
    dbg_rd(8'h01, v); check("t7_reg1", v, 8'h3C);

    repeat (10) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
